// File: rtl/VX_tb_common_pkg.sv
// Shared definitions for the scheduler event monitor: event kinds,
// capture channel indices and the drop counter width.
package VX_tb_common_pkg;

    typedef enum logic [1:0] {
        SCHED_EVT_WCTL   = 2'd0,
        SCHED_EVT_WSPAWN = 2'd1,
        SCHED_EVT_JOIN   = 2'd2,
        SCHED_EVT_BRANCH = 2'd3
    } sched_evt_kind_e;

    // Capture channel order; branch lanes follow from SCHED_CH_BR0 upward.
    localparam int SCHED_CH_WCTL   = 0;
    localparam int SCHED_CH_WSPAWN = 1;
    localparam int SCHED_CH_JOIN   = 2;
    localparam int SCHED_CH_BR0    = 3;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/vx_sched_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// one grant per cycle, gated by an enable. Pointer advances past the winner.
module vx_sched_rr_arb
    import VX_tb_common_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    logic [IDX_W-1:0] ptr_q;

    // Search from the pointer; iterating offsets downward lets the nearest requester win.
    always_comb begin
        int c;
        c       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            c = int'(ptr_q) + k;
            if (c >= NUM_CH) begin
                c = c - NUM_CH;
            end
            if (req[c]) begin
                gnt_idx = IDX_W'(c);
                gnt_vld = 1'b1;
            end
        end
        gnt_vld = gnt_vld & en;
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Pointer moves to the channel after the winner; holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (gnt_vld) begin
            if (int'(gnt_idx) == NUM_CH - 1) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= gnt_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/vx_sched_event_monitor.sv
// Scheduler event monitor: timestamps warp-control, wspawn, join and
// per-lane branch events, stages each source in a one-deep slot, merges
// them round-robin into a FIFO and drains it over a valid/ready stream.
module vx_sched_event_monitor
    import VX_tb_common_pkg::*;
#(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_THREADS  = 4,
    parameter int NUM_BR_LANES = 1,
    parameter int PC_BITS      = 30,
    parameter int DEPTH        = 8,
    parameter int TS_W         = 32,
    parameter int MASK_W       = (NUM_WARPS > NUM_THREADS) ? NUM_WARPS : NUM_THREADS,
    localparam int NW_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int LANE_W      = $clog2(NUM_BR_LANES) + 1,
    localparam int FILL_W      = $clog2(DEPTH) + 1,
    localparam int NUM_CH      = 3 + NUM_BR_LANES
)(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wctl_valid,
    input  logic [NW_W-1:0]                 wctl_wid,
    input  logic [NUM_THREADS-1:0]          wctl_tmask,
    input  logic [PC_BITS-1:0]              wctl_pc,
    input  logic                            wspawn_valid,
    input  logic [NUM_WARPS-1:0]            wspawn_wmask,
    input  logic [PC_BITS-1:0]              wspawn_pc,
    input  logic                            join_valid,
    input  logic [NW_W-1:0]                 join_wid,
    input  logic [NUM_THREADS-1:0]          join_tmask,
    input  logic [PC_BITS-1:0]              join_pc,
    input  logic [NUM_BR_LANES-1:0]         br_valid,
    input  logic [NUM_BR_LANES*NW_W-1:0]    br_wid,
    input  logic [NUM_BR_LANES-1:0]         br_taken,
    input  logic [NUM_BR_LANES*PC_BITS-1:0] br_target,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [1:0]                      evt_kind,
    output logic [LANE_W-1:0]               evt_lane,
    output logic [NW_W-1:0]                 evt_wid,
    output logic [MASK_W-1:0]               evt_mask,
    output logic [PC_BITS-1:0]              evt_pc,
    output logic                            evt_taken,
    output logic [TS_W-1:0]                 evt_ts,
    output logic [FILL_W-1:0]               fill_level,
    output logic [DROP_CNT_W-1:0]           drop_cnt,
    output logic [NUM_CH-1:0]               drop_sticky
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]         kind;
        logic [LANE_W-1:0]  lane;
        logic [NW_W-1:0]    wid;
        logic [MASK_W-1:0]  mask;
        logic [PC_BITS-1:0] pc;
        logic               taken;
        logic [TS_W-1:0]    ts;
    } evt_t;

    // Saturating add of this cycle's drop count onto the running total.
    function automatic logic [DROP_CNT_W-1:0] sat_add(
        input logic [DROP_CNT_W-1:0] base,
        input logic [CH_W:0]         inc
    );
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, base} + {{(DROP_CNT_W - CH_W){1'b0}}, inc};
        return sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : sum[DROP_CNT_W-1:0];
    endfunction

    logic [TS_W-1:0]       ts_q;
    logic [NUM_CH-1:0]     src_vld;
    evt_t                  src_evt [NUM_CH];
    logic [NUM_CH-1:0]     slot_vld;
    evt_t                  slot_evt [NUM_CH];
    logic [NUM_CH-1:0]     load;
    logic [NUM_CH-1:0]     drop;
    logic [CH_W:0]         drop_n;
    logic [NUM_CH-1:0]     gnt;
    logic [CH_W-1:0]       gnt_idx;
    logic                  gnt_vld;
    logic                  arb_en;
    logic                  push;
    logic                  pop;
    evt_t                  mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [FILL_W-1:0]     fill_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic [NUM_CH-1:0]     drop_sticky_q;
    evt_t                  head;

    assign src_vld = {br_valid, join_valid, wspawn_valid, wctl_valid};

    // Normalise every source into the common payload, stamped with the current time.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            src_evt[c]    = '0;
            src_evt[c].ts = ts_q;
        end
        src_evt[SCHED_CH_WCTL].kind   = SCHED_EVT_WCTL;
        src_evt[SCHED_CH_WCTL].wid    = wctl_wid;
        src_evt[SCHED_CH_WCTL].mask   = MASK_W'(wctl_tmask);
        src_evt[SCHED_CH_WCTL].pc     = wctl_pc;
        src_evt[SCHED_CH_WSPAWN].kind = SCHED_EVT_WSPAWN;
        src_evt[SCHED_CH_WSPAWN].mask = MASK_W'(wspawn_wmask);
        src_evt[SCHED_CH_WSPAWN].pc   = wspawn_pc;
        src_evt[SCHED_CH_JOIN].kind   = SCHED_EVT_JOIN;
        src_evt[SCHED_CH_JOIN].wid    = join_wid;
        src_evt[SCHED_CH_JOIN].mask   = MASK_W'(join_tmask);
        src_evt[SCHED_CH_JOIN].pc     = join_pc;
        for (int i = 0; i < NUM_BR_LANES; i++) begin
            src_evt[SCHED_CH_BR0 + i].kind  = SCHED_EVT_BRANCH;
            src_evt[SCHED_CH_BR0 + i].lane  = LANE_W'(i);
            src_evt[SCHED_CH_BR0 + i].wid   = br_wid[i*NW_W +: NW_W];
            src_evt[SCHED_CH_BR0 + i].pc    = br_target[i*PC_BITS +: PC_BITS];
            src_evt[SCHED_CH_BR0 + i].taken = br_taken[i];
        end
    end

    // A slot accepts a new event when empty or when its current one is leaving this cycle.
    assign load = src_vld & (~slot_vld | gnt);
    assign drop = src_vld & slot_vld & ~gnt;

    // Number of channels that lost an event this cycle.
    always_comb begin
        drop_n = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            drop_n = drop_n + {{CH_W{1'b0}}, drop[c]};
        end
    end

    // Staging slot occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_vld <= '0;
        end else begin
            slot_vld <= load | (slot_vld & ~gnt);
        end
    end

    // Staging slot payload; only meaningful while the matching slot_vld is set.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (load[c]) begin
                slot_evt[c] <= src_evt[c];
            end
        end
    end

    // Timestamp, drop counter and per-channel drop flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q          <= '0;
            drop_cnt_q    <= '0;
            drop_sticky_q <= '0;
        end else begin
            ts_q          <= ts_q + TS_W'(1);
            drop_cnt_q    <= sat_add(drop_cnt_q, drop_n);
            drop_sticky_q <= drop_sticky_q | drop;
        end
    end

    // A pop frees an entry in the same cycle, so a full FIFO can still accept a grant.
    assign pop    = evt_valid & evt_ready;
    assign arb_en = (fill_q != FILL_W'(DEPTH)) | pop;
    assign push   = gnt_vld;

    vx_sched_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (slot_vld),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (push && !pop) begin
                fill_q <= fill_q + FILL_W'(1);
            end else if (pop && !push) begin
                fill_q <= fill_q - FILL_W'(1);
            end
        end
    end

    // FIFO storage write of the granted slot.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= slot_evt[gnt_idx];
        end
    end

    assign head       = mem[rd_ptr];
    assign evt_valid  = (fill_q != '0);
    assign fill_level = fill_q;
    assign drop_cnt   = drop_cnt_q;
    assign drop_sticky = drop_sticky_q;

    // Head payload is forced to zero when empty so stale storage never leaks out.
    always_comb begin
        evt_kind  = '0;
        evt_lane  = '0;
        evt_wid   = '0;
        evt_mask  = '0;
        evt_pc    = '0;
        evt_taken = 1'b0;
        evt_ts    = '0;
        if (evt_valid) begin
            evt_kind  = head.kind;
            evt_lane  = head.lane;
            evt_wid   = head.wid;
            evt_mask  = head.mask;
            evt_pc    = head.pc;
            evt_taken = head.taken;
            evt_ts    = head.ts;
        end
    end

endmodule

// File: tb/tb_vx_sched_event_monitor.sv
// Directed bench for vx_sched_event_monitor with default parameters.
module tb_vx_sched_event_monitor;

    localparam int NW_W    = 2;
    localparam int PC_BITS = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        wctl_valid;
    logic [1:0]  wctl_wid;
    logic [3:0]  wctl_tmask;
    logic [29:0] wctl_pc;
    logic        wspawn_valid;
    logic [3:0]  wspawn_wmask;
    logic [29:0] wspawn_pc;
    logic        join_valid;
    logic [1:0]  join_wid;
    logic [3:0]  join_tmask;
    logic [29:0] join_pc;
    logic [0:0]  br_valid;
    logic [1:0]  br_wid;
    logic [0:0]  br_taken;
    logic [29:0] br_target;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_kind;
    logic [0:0]  evt_lane;
    logic [1:0]  evt_wid;
    logic [3:0]  evt_mask;
    logic [29:0] evt_pc;
    logic        evt_taken;
    logic [31:0] evt_ts;
    logic [3:0]  fill_level;
    logic [15:0] drop_cnt;
    logic [3:0]  drop_sticky;

    int checks = 0;
    int errors = 0;
    int ts_model = 0;
    int ts2;
    int tsb0;

    always #5 clk = ~clk;

    vx_sched_event_monitor #(
        .NUM_WARPS    (4),
        .NUM_THREADS  (4),
        .NUM_BR_LANES (1),
        .PC_BITS      (PC_BITS),
        .DEPTH        (8),
        .TS_W         (32),
        .MASK_W       (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wctl_valid   (wctl_valid),
        .wctl_wid     (wctl_wid),
        .wctl_tmask   (wctl_tmask),
        .wctl_pc      (wctl_pc),
        .wspawn_valid (wspawn_valid),
        .wspawn_wmask (wspawn_wmask),
        .wspawn_pc    (wspawn_pc),
        .join_valid   (join_valid),
        .join_wid     (join_wid),
        .join_tmask   (join_tmask),
        .join_pc      (join_pc),
        .br_valid     (br_valid),
        .br_wid       (br_wid),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_kind     (evt_kind),
        .evt_lane     (evt_lane),
        .evt_wid      (evt_wid),
        .evt_mask     (evt_mask),
        .evt_pc       (evt_pc),
        .evt_taken    (evt_taken),
        .evt_ts       (evt_ts),
        .fill_level   (fill_level),
        .drop_cnt     (drop_cnt),
        .drop_sticky  (drop_sticky)
    );

    // One clock edge; tracks the expected timestamp counter value after the edge.
    task automatic tick();
        logic r;
        @(posedge clk);
        r = reset;
        #1;
        if (r) ts_model = 0;
        else   ts_model = ts_model + 1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        wctl_valid   = 1'b0; wctl_wid = '0; wctl_tmask = '0; wctl_pc = '0;
        wspawn_valid = 1'b0; wspawn_wmask = '0; wspawn_pc = '0;
        join_valid   = 1'b0; join_wid = '0; join_tmask = '0; join_pc = '0;
        br_valid     = '0; br_wid = '0; br_taken = '0; br_target = '0;
        evt_ready    = 1'b1;
        #1;
        tick();
        tick();

        // Reset state
        check("rst_valid",  64'(evt_valid),   64'd0);
        check("rst_fill",   64'(fill_level),  64'd0);
        check("rst_drop",   64'(drop_cnt),    64'd0);
        check("rst_sticky", 64'(drop_sticky), 64'd0);
        check("rst_ts",     64'(evt_ts),      64'd0);
        check("rst_kind",   64'(evt_kind),    64'd0);

        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Single wctl event sampled at ts=5
        wctl_valid = 1'b1; wctl_wid = 2'd2; wctl_tmask = 4'b1010; wctl_pc = 30'h100;
        tick();
        wctl_valid = 1'b0;
        check("t1_not_yet", 64'(evt_valid), 64'd0);
        tick();
        check("t1_valid", 64'(evt_valid), 64'd1);
        check("t1_kind",  64'(evt_kind),  64'd0);
        check("t1_wid",   64'(evt_wid),   64'd2);
        check("t1_mask",  64'(evt_mask),  64'hA);
        check("t1_pc",    64'(evt_pc),    64'h100);
        check("t1_ts",    64'(evt_ts),    64'd5);
        check("t1_fill",  64'(fill_level), 64'd1);
        tick();
        check("t1_drained", 64'(fill_level), 64'd0);
        check("t1_vld_low", 64'(evt_valid),  64'd0);

        // wspawn: wid and taken must read zero even with stale branch inputs
        br_taken = 1'b1;
        wspawn_valid = 1'b1; wspawn_wmask = 4'b0110; wspawn_pc = 30'h200;
        tick();
        wspawn_valid = 1'b0;
        tick();
        check("ws_valid", 64'(evt_valid), 64'd1);
        check("ws_kind",  64'(evt_kind),  64'd1);
        check("ws_wid",   64'(evt_wid),   64'd0);
        check("ws_mask",  64'(evt_mask),  64'h6);
        check("ws_pc",    64'(evt_pc),    64'h200);
        check("ws_taken", 64'(evt_taken), 64'd0);
        check("ws_lane",  64'(evt_lane),  64'd0);
        tick();
        check("ws_drained", 64'(evt_valid), 64'd0);

        // Branch flood with consumer stalled: 8 in FIFO, 1 staged, 3 dropped
        evt_ready = 1'b0;
        tsb0 = ts_model;
        for (int k = 0; k < 12; k++) begin
            br_valid = 1'b1; br_wid = 2'(k); br_taken = 1'(k); br_target = 30'h1000 + 30'(k);
            tick();
        end
        br_valid = 1'b0;
        check("fl_fill",   64'(fill_level),  64'd8);
        check("fl_drop",   64'(drop_cnt),    64'd3);
        check("fl_sticky", 64'(drop_sticky), 64'b1000);
        check("fl_valid",  64'(evt_valid),   64'd1);
        check("fl_head_pc", 64'(evt_pc),     64'h1000);
        check("fl_head_ts", 64'(evt_ts),     64'(tsb0));
        tick();
        tick();
        check("fl_stable_pc",   64'(evt_pc),     64'h1000);
        check("fl_stable_ts",   64'(evt_ts),     64'(tsb0));
        check("fl_stable_kind", 64'(evt_kind),   64'd3);
        check("fl_stable_fill", 64'(fill_level), 64'd8);

        // Drain: 9 events in increasing ts order, staged one enters as the first pops
        evt_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check("dr_valid", 64'(evt_valid), 64'd1);
            check("dr_pc",    64'(evt_pc),    64'h1000 + 64'(k));
            check("dr_ts",    64'(evt_ts),    64'(tsb0 + k));
            check("dr_wid",   64'(evt_wid),   64'(k % 4));
            tick();
        end
        check("dr_empty", 64'(evt_valid),  64'd0);
        check("dr_fill0", 64'(fill_level), 64'd0);
        check("dr_drop",  64'(drop_cnt),   64'd3);

        // Three channels at once: grants 0, 2, 3 with identical timestamps
        ts2 = ts_model;
        wctl_valid = 1'b1; wctl_wid = 2'd1; wctl_tmask = 4'hF; wctl_pc = 30'h10;
        join_valid = 1'b1; join_wid = 2'd3; join_tmask = 4'h3; join_pc = 30'h20;
        br_valid = 1'b1; br_wid = 2'd2; br_taken = 1'b1; br_target = 30'h30;
        tick();
        wctl_valid = 1'b0; join_valid = 1'b0; br_valid = 1'b0;
        tick();
        check("mc0_kind", 64'(evt_kind), 64'd0);
        check("mc0_wid",  64'(evt_wid),  64'd1);
        check("mc0_mask", 64'(evt_mask), 64'hF);
        check("mc0_pc",   64'(evt_pc),   64'h10);
        check("mc0_ts",   64'(evt_ts),   64'(ts2));
        tick();
        check("mc1_kind", 64'(evt_kind), 64'd2);
        check("mc1_wid",  64'(evt_wid),  64'd3);
        check("mc1_mask", 64'(evt_mask), 64'h3);
        check("mc1_pc",   64'(evt_pc),   64'h20);
        check("mc1_ts",   64'(evt_ts),   64'(ts2));
        tick();
        check("mc2_kind",  64'(evt_kind),  64'd3);
        check("mc2_wid",   64'(evt_wid),   64'd2);
        check("mc2_taken", 64'(evt_taken), 64'd1);
        check("mc2_lane",  64'(evt_lane),  64'd0);
        check("mc2_pc",    64'(evt_pc),    64'h30);
        check("mc2_ts",    64'(evt_ts),    64'(ts2));
        tick();
        check("mc_empty", 64'(evt_valid), 64'd0);
        check("mc_drop",  64'(drop_cnt),  64'd3);

        // Reset with 5 FIFO entries and a full staging slot
        evt_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            br_valid = 1'b1; br_target = 30'h2000 + 30'(k);
            tick();
        end
        br_valid = 1'b0;
        check("pre_rst_fill", 64'(fill_level), 64'd5);
        reset = 1'b1;
        wctl_valid = 1'b1; wctl_wid = 2'd3; wctl_pc = 30'h77;
        tick();
        reset = 1'b0;
        wctl_valid = 1'b0;
        check("mr_valid",  64'(evt_valid),   64'd0);
        check("mr_fill",   64'(fill_level),  64'd0);
        check("mr_drop",   64'(drop_cnt),    64'd0);
        check("mr_sticky", 64'(drop_sticky), 64'd0);
        check("mr_pc",     64'(evt_pc),      64'd0);
        check("mr_ts",     64'(evt_ts),      64'd0);
        evt_ready = 1'b1;
        tick();
        tick();
        tick();
        check("mr_no_ghost", 64'(evt_valid), 64'd0);
        wctl_valid = 1'b1; wctl_wid = 2'd1; wctl_tmask = 4'h5; wctl_pc = 30'h55;
        tick();
        wctl_valid = 1'b0;
        tick();
        check("mr_ev_valid", 64'(evt_valid), 64'd1);
        check("mr_ev_pc",    64'(evt_pc),    64'h55);
        check("mr_ev_ts",    64'(evt_ts),    64'd3);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_sched_event_monitor.md
Name: vx_sched_event_monitor

Overview:
Testbench-side capture block for scheduler control events (warp control, wspawn, join, and multi-lane branch resolution). It timestamps every event, holds each source in a one-deep staging slot, and arbitrates round-robin into a single FIFO. Events drain over a valid/ready stream to the scheduler scoreboard. It generalises the single-bundle scheduler observation to N branch lanes, adds buffering and back-pressure, and accounts for dropped events.

Parameters:
NUM_WARPS, 4, warps per core; NW_W = max(1, clog2(NUM_WARPS))
NUM_THREADS, 4, threads per warp
NUM_BR_LANES, 1, branch-resolution lanes (ALU blocks); NUM_CH = 3 + NUM_BR_LANES
PC_BITS, 30, PC width
DEPTH, 8, FIFO entries; power of two, at least 2
TS_W, 32, timestamp width
MASK_W, max(NUM_WARPS, NUM_THREADS), width of the event mask field

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wctl_valid  in  1  warp-control event
wctl_wid  in  NW_W  warp id
wctl_tmask  in  NUM_THREADS  resulting thread mask
wctl_pc  in  PC_BITS  result PC
wspawn_valid  in  1  wspawn event
wspawn_wmask  in  NUM_WARPS  warps being spawned
wspawn_pc  in  PC_BITS  spawn PC
join_valid  in  1  join event
join_wid  in  NW_W  warp id
join_tmask  in  NUM_THREADS  restored thread mask
join_pc  in  PC_BITS  restored PC
br_valid  in  NUM_BR_LANES  branch resolved, per lane
br_wid  in  NUM_BR_LANES*NW_W  per-lane warp id
br_taken  in  NUM_BR_LANES  per-lane taken
br_target  in  NUM_BR_LANES*PC_BITS  per-lane target
evt_valid  out  1  head event available
evt_ready  in  1  consumer accepts
evt_kind  out  2  0=WCTL, 1=WSPAWN, 2=JOIN, 3=BRANCH
evt_lane  out  clog2(NUM_BR_LANES)+1  branch lane; 0 for other kinds
evt_wid  out  NW_W  warp id; 0 for WSPAWN
evt_mask  out  MASK_W  tmask, or wmask for WSPAWN; zero-extended
evt_pc  out  PC_BITS  PC or target
evt_taken  out  1  branch taken; 0 for other kinds
evt_ts  out  TS_W  capture timestamp
fill_level  out  clog2(DEPTH)+1  FIFO occupancy
drop_cnt  out  16  saturating count of dropped events
drop_sticky  out  NUM_CH  per-channel drop flag, cleared only by reset

Behaviour:
- Reset values: all outputs 0; timestamp counter 0; staging slots empty; FIFO empty; arbiter pointer at channel 0.
- Timestamp: free-running counter, +1 per cycle, wraps modulo 2^TS_W. An event sampled at edge t carries ts(t).
- Channel order: 0=WCTL, 1=WSPAWN, 2=JOIN, 3+i=BRANCH lane i.
- Staging: a source valid loads its slot if the slot is empty, or if it is granted in the same cycle (back-to-back with no bubble).
- Drop rule: if the slot is full and not granted, the new event is dropped. drop_cnt increments, saturating at 0xFFFF. drop_sticky[c] is set. The staged event is kept.
- Multiple channels dropping in one cycle add the number of drops, still saturating.
- Arbiter: round-robin over occupied slots, one grant per cycle.
  - A grant requires fill_level < DEPTH, or a pop in the same cycle.
  - After a grant, the pointer moves to grant+1 modulo NUM_CH.
  - With no grant, the pointer holds.
- FIFO: the granted slot is written the same cycle. The head drives evt_* combinationally from storage.
  - evt_valid = (fill_level != 0).
  - Pop on evt_valid & evt_ready.
  - Simultaneous push and pop leaves fill_level unchanged; pointers wrap modulo DEPTH.
  - evt_* payload is stable while evt_valid & !evt_ready.
- Latency: with an empty FIFO and no contention, an event at edge t is staged at t, written at t+1, and visible on evt_* after the t+1 edge. Minimum is 2 cycles from source to output.
- Ordering: per-channel order is preserved. Cross-channel order follows grants; the consumer sorts by evt_ts.
- Full FIFO: slots hold their events, and a slot that is still full when its source fires again drops.
- Reset mid-operation: clears everything in one cycle, with no drain. Events presented in the reset cycle are discarded and not counted.
- X on a source payload while its valid is low is ignored.

Decomposition:
- VX_tb_common_pkg:
  - sched_evt_kind_e enum (WCTL, WSPAWN, JOIN, BRANCH)
  - channel-index constants SCHED_CH_WCTL / _WSPAWN / _JOIN / _BR0
  - DROP_CNT_W = 16
- The payload struct stays local to the module, since its widths depend on the parameters.
- One sub-module: vx_sched_rr_arb, a parametrised NUM_CH round-robin arbiter with a grant-enable input, one-hot grant, and an index output.

Test Plan:
- Single wctl event (wid=2, tmask=4'b1010, pc=0x100) at ts=5 with evt_ready=1 -> evt_valid high 2 cycles later; kind=0, wid=2, mask=0xA, pc=0x100, ts=5; then fill_level returns to 0.
- wctl, join, and br lane0 all fire in the same cycle, FIFO empty -> grants in order 0, 2, 3 on three consecutive cycles; all carry an identical ts; drop_cnt=0.
- evt_ready=0, br lane0 fires every cycle for 12 cycles (DEPTH=8) -> 8 in FIFO, 1 staged, 3 dropped; drop_cnt=3; drop_sticky=4'b1000; head payload stable.
- Same as the previous scenario, then evt_ready=1 -> exactly 9 events drain, in increasing ts order; evt_valid then deasserts.
- wspawn with wmask=4'b0110, pc=0x200 -> kind=1, wid=0, mask=0x6, taken=0.
- Reset asserted with 5 entries in the FIFO and a full staging slot -> next cycle all outputs 0; fill_level=0; a subsequent event shows ts counted from 0.
